// File: rtl/fp_mul128_sched_if.sv
// Request/result bundle for fp_mul128_sched.
// The requester side drives the packed per-requester operands and accepts results.
// The scheduler side grants requests and presents results.
interface fp_mul128_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_a;
  logic [NREQ*128-1:0] req_b;
  logic [NREQ*3-1:0]   req_rm;
  logic                res_valid;
  logic                res_ready;
  logic [IDW-1:0]      res_id;
  logic [127:0]        res_o;
  logic [3:0]          res_flags;

  modport master (
    output req_valid, req_a, req_b, req_rm, res_ready,
    input  req_ready, res_valid, res_id, res_o, res_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_rm, res_ready,
    output req_ready, res_valid, res_id, res_o, res_flags
  );
endinterface

// File: rtl/fp_mul128_sched.sv
// fp_mul128_sched: round-robin scheduler sharing one pipelined 128-bit IEEE
// multiplier among NREQ requesters. A tag pipeline of depth LAT follows every
// operation so the result returns with its requester id; the rounding mode is
// delayed RM_DLY stages to reach the multiplier's round stage. Back-pressure on
// the result port freezes the whole multiplier through mul_ce.
// Optional statistics counters are built when FP_MUL128_SCHED_STATS_EN is defined.
module fp_mul128_sched #(
  parameter int NREQ   = 4,
  parameter int LAT    = 10,
  parameter int RM_DLY = 8,
  parameter int IDW    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fp_mul128_sched_if.slave         bus,
  output logic                     mul_ce,
  output logic [127:0]             mul_a,
  output logic [127:0]             mul_b,
  output logic [2:0]               mul_rm,
  input  logic [127:0]             mul_o,
  input  logic [3:0]               mul_flags,
  input  logic                     drain,
  output logic                     drain_done,
  output logic [$clog2(LAT+1)-1:0] inflight
`ifdef FP_MUL128_SCHED_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [31:0]              issue_cnt,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                   state_r;
  logic                     drain_done_r;
  logic [IDW-1:0]           ptr_r;
  logic [CW-1:0]            inflight_r;
  logic [CW-1:0]            inflight_nxt_s;
  logic [LAT-1:0]           tag_vld_r;
  logic [IDW-1:0]           tag_id_r [LAT];
  logic [2:0]               rm_dly_r [RM_DLY];

  logic                     stall_s;
  logic                     ce_s;
  logic                     found_s;
  logic [IDW-1:0]           winner_s;
  logic                     accept_en_s;
  logic                     issue_s;
  logic                     consume_s;
  logic                     empty_nxt_s;
  logic [NREQ-1:0]          req_ready_s;
  logic [127:0]             mul_a_s;
  logic [127:0]             mul_b_s;
  logic [2:0]               rm_in_s;

  // A result held at the tail that the consumer refuses freezes the whole pipe.
  assign stall_s   = tag_vld_r[LAT-1] & ~bus.res_ready;
  assign ce_s      = ~stall_s;
  assign consume_s = tag_vld_r[LAT-1] & bus.res_ready;

  // Grants are withheld while stalled, while draining, and when drain is requested.
  assign accept_en_s = ce_s & (state_r != ST_DRAIN) & ~drain;
  assign issue_s     = found_s & accept_en_s;

  // Round-robin search starting at the pointer; first valid requester wins.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_r) + k) % NREQ;
      if (!found_s && bus.req_valid[idx]) begin
        found_s  = 1'b1;
        winner_s = IDW'(idx);
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Drive the grant vector and the winner's operands in the accepting cycle.
  always_comb begin
    req_ready_s = '0;
    mul_a_s     = 128'd0;
    mul_b_s     = 128'd0;
    rm_in_s     = 3'd0;
    if (issue_s) begin
      req_ready_s[winner_s] = 1'b1;
      mul_a_s = bus.req_a[128*winner_s +: 128];
      mul_b_s = bus.req_b[128*winner_s +: 128];
      rm_in_s = bus.req_rm[3*winner_s +: 3];
    end else begin
      req_ready_s = '0;
    end
  end

  // Occupancy update: an issue and a retire in the same cycle cancel out.
  always_comb begin
    case ({issue_s, consume_s})
      2'b10:   inflight_nxt_s = inflight_r + CW'(1);
      2'b01:   inflight_nxt_s = inflight_r - CW'(1);
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  assign empty_nxt_s = (inflight_nxt_s == '0);

  // Tag pipeline: carries {valid, id} alongside each operation, frozen on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_r <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_id_r[i] <= '0;
      end
    end else if (ce_s) begin
      tag_vld_r   <= {tag_vld_r[LAT-2:0], issue_s};
      tag_id_r[0] <= issue_s ? winner_s : '0;
      for (int i = 1; i < LAT; i++) begin
        tag_id_r[i] <= tag_id_r[i-1];
      end
    end
  end

  // Rounding-mode delay line so the mode meets its operation at the round stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RM_DLY; i++) begin
        rm_dly_r[i] <= 3'd0;
      end
    end else if (ce_s) begin
      rm_dly_r[0] <= rm_in_s;
      for (int i = 1; i < RM_DLY; i++) begin
        rm_dly_r[i] <= rm_dly_r[i-1];
      end
    end
  end

  // Round-robin pointer moves past the winner only on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (issue_s) begin
      ptr_r <= (winner_s == IDW'(NREQ - 1)) ? '0 : winner_s + IDW'(1);
    end
  end

  // Count of operations between issue and result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= '0;
    end else begin
      inflight_r <= inflight_nxt_s;
    end
  end

  // Control FSM: busy/drain tracking and the one-cycle drain-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      drain_done_r <= 1'b0;
    end else begin
      drain_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (drain) begin
            if (empty_nxt_s) begin
              drain_done_r <= 1'b1;
              state_r      <= ST_IDLE;
            end else begin
              state_r <= ST_DRAIN;
            end
          end else if (issue_s) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (drain) begin
            if (empty_nxt_s) begin
              drain_done_r <= 1'b1;
              state_r      <= ST_IDLE;
            end else begin
              state_r <= ST_DRAIN;
            end
          end else if (empty_nxt_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (empty_nxt_s) begin
            drain_done_r <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FP_MUL128_SCHED_STATS_EN
  logic [31:0] issue_cnt_r;
  logic [31:0] stall_cnt_r;

  // Saturating handshake and stall-cycle counters with synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else if (stats_clr) begin
      issue_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (issue_s && (issue_cnt_r != 32'hFFFF_FFFF)) begin
        issue_cnt_r <= issue_cnt_r + 32'd1;
      end
      if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign issue_cnt = issue_cnt_r;
  assign stall_cnt = stall_cnt_r;
`endif

  assign bus.req_ready = req_ready_s;
  assign bus.res_valid = tag_vld_r[LAT-1];
  assign bus.res_id    = tag_id_r[LAT-1];
  assign bus.res_o     = mul_o;
  assign bus.res_flags = mul_flags;
  assign mul_ce        = ce_s;
  assign mul_a         = mul_a_s;
  assign mul_b         = mul_b_s;
  assign mul_rm        = rm_dly_r[RM_DLY-1];
  assign drain_done    = drain_done_r;
  assign inflight      = inflight_r;

endmodule

// File: tb/tb_fp_mul128_sched.sv
// Directed bench for fp_mul128_sched. A small behavioural multiplier stands in
// for the real core: it knows two hand-computed quad-precision products and
// otherwise returns a ^ b with flags = a[3:0]; it applies round-to-nearest
// (rm 0) or truncation (rm 1) at stage RM_DLY using mul_rm.
module tb_fp_mul128_sched;
  localparam int NREQ   = 4;
  localparam int LAT    = 10;
  localparam int RM_DLY = 8;
  localparam int IDW    = 3;

  localparam logic [127:0] ONE   = 128'h3FFF_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] TWO   = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] XQ    = 128'h3FFF_8000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] P_RTZ = 128'h4000_2000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] P_RNE = 128'h4000_2000_0000_0000_0000_0000_0000_0002;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mul_ce;
  logic [127:0] mul_a, mul_b, mul_o;
  logic [2:0]   mul_rm;
  logic [3:0]   mul_flags;
  logic         drain = 1'b0;
  logic         drain_done;
  logic [3:0]   inflight;
  int           n_chk = 0;
  int           n_err = 0;

  fp_mul128_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef FP_MUL128_SCHED_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] issue_cnt, stall_cnt;
`endif

  fp_mul128_sched #(.NREQ(NREQ), .LAT(LAT), .RM_DLY(RM_DLY), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm),
    .mul_o(mul_o), .mul_flags(mul_flags),
    .drain(drain), .drain_done(drain_done), .inflight(inflight)
`ifdef FP_MUL128_SCHED_STATS_EN
    , .stats_clr(stats_clr), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural multiplier model
  logic [127:0] m_val [LAT];
  logic         m_rup [LAT];
  logic [3:0]   m_flg [LAT];

  function automatic logic [132:0] mdl_prod(input logic [127:0] a, input logic [127:0] b);
    if (a == ONE && b == TWO) return {1'b0, 4'h0, TWO};
    else if (a == XQ && b == XQ) return {1'b1, 4'h0, P_RTZ};
    else return {1'b0, a[3:0], a ^ b};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        m_val[i] <= '0;
        m_rup[i] <= 1'b0;
        m_flg[i] <= '0;
      end
    end else if (mul_ce) begin
      {m_rup[0], m_flg[0], m_val[0]} <= mdl_prod(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) begin
        if (i == RM_DLY)
          m_val[i] <= (mul_rm == 3'd0) ? m_val[i-1] + {127'd0, m_rup[i-1]} : m_val[i-1];
        else
          m_val[i] <= m_val[i-1];
        m_rup[i] <= m_rup[i-1];
        m_flg[i] <= m_flg[i-1];
      end
    end
  end

  assign mul_o     = m_val[LAT-1];
  assign mul_flags = m_flg[LAT-1];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [127:0] a, input logic [127:0] b, input logic [2:0] rm);
    bus.req_a[128*i +: 128] = a;
    bus.req_b[128*i +: 128] = b;
    bus.req_rm[3*i +: 3]    = rm;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_rm    = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 128'(i + 1), 128'd0, 3'd0);

    // Reset values
    go(); go();
    #3;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_mul_ce", mul_ce, 1);
    chk("rst_inflight", inflight, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_mul_rm", mul_rm, 0);
    go();
    rst_n = 1'b1;

    // Round robin: all four requesters for 8 cycles
    for (int c = 0; c < 19; c++) begin
      go();
      bus.req_valid = (c < 8) ? 4'hF : 4'h0;
      #3;
      if (c < 8) begin
        chk("rr_grant", bus.req_ready, 4'b0001 << (c % 4));
        chk("rr_mul_a", mul_a, 128'(c % 4 + 1));
      end
      if (c == 8) chk("rr_inflight_peak", inflight, 8);
      if (c == 9) chk("rr_early", bus.res_valid, 0);
      if (c >= 10 && c < 18) begin
        chk("rr_res_valid", bus.res_valid, 1);
        chk("rr_res_id", bus.res_id, 128'((c - 10) % 4));
        chk("rr_res_o", bus.res_o, 128'((c - 10) % 4 + 1));
        chk("rr_res_flags", bus.res_flags, 128'((c - 10) % 4 + 1));
      end
      if (c == 18) begin
        chk("rr_end_valid", bus.res_valid, 0);
        chk("rr_end_inflight", inflight, 0);
      end
    end

    // Single op: requester 2, 1.0 * 2.0
    go();
    set_op(2, ONE, TWO, 3'd0);
    bus.req_valid = 4'b0100;
    #3;
    chk("one_grant", bus.req_ready, 4'b0100);
    chk("one_mul_a", mul_a, ONE);
    chk("one_mul_b", mul_b, TWO);
    for (int k = 1; k <= 11; k++) begin
      go();
      bus.req_valid = 4'h0;
      #3;
      if (k == 1) chk("one_inflight", inflight, 1);
      if (k < 10) chk("one_early", bus.res_valid, 0);
      if (k == 10) begin
        chk("one_res_valid", bus.res_valid, 1);
        chk("one_res_id", bus.res_id, 2);
        chk("one_res_o", bus.res_o, TWO);
        chk("one_res_flags", bus.res_flags, 0);
      end
      if (k == 11) chk("one_after", bus.res_valid, 0);
    end

    // Stall: pointer at 3, grants 0,1,0; consumer refuses for 5 cycles
    go();
    bus.req_valid = 4'b0011;
    set_op(0, 128'h11, 128'd0, 3'd0);
    set_op(1, 128'h22, 128'd0, 3'd0);
    #3;
    chk("stl_grant0", bus.req_ready, 4'b0001);
    go();
    #3;
    chk("stl_grant1", bus.req_ready, 4'b0010);
    go();
    set_op(0, 128'h33, 128'd0, 3'd0);
    #3;
    chk("stl_grant2", bus.req_ready, 4'b0001);
    for (int s = 3; s < 19; s++) begin
      go();
      bus.req_valid = (s >= 10 && s < 15) ? 4'b0100 : 4'b0000;
      bus.res_ready = !(s >= 10 && s < 15);
      #3;
      if (s >= 10 && s < 15) begin
        chk("stl_mul_ce", mul_ce, 0);
        chk("stl_req_ready", bus.req_ready, 0);
        chk("stl_hold_valid", bus.res_valid, 1);
        chk("stl_hold_o", bus.res_o, 128'h11);
        chk("stl_hold_id", bus.res_id, 0);
      end
      if (s == 15) begin
        chk("stl_r0_o", bus.res_o, 128'h11);
        chk("stl_r0_ce", mul_ce, 1);
      end
      if (s == 16) begin
        chk("stl_r1_o", bus.res_o, 128'h22);
        chk("stl_r1_id", bus.res_id, 1);
      end
      if (s == 17) begin
        chk("stl_r2_o", bus.res_o, 128'h33);
        chk("stl_r2_id", bus.res_id, 0);
        chk("stl_r2_flags", bus.res_flags, 3);
      end
      if (s == 18) chk("stl_none", bus.res_valid, 0);
    end

    // Rounding-mode alignment: requester 1, rm 0 then rm 1
    go();
    set_op(1, XQ, XQ, 3'd0);
    bus.req_valid = 4'b0010;
    #3;
    chk("rm_grant0", bus.req_ready, 4'b0010);
    go();
    set_op(1, XQ, XQ, 3'd1);
    #3;
    chk("rm_grant1", bus.req_ready, 4'b0010);
    for (int t = 2; t <= 12; t++) begin
      go();
      bus.req_valid = 4'h0;
      #3;
      if (t == 8) chk("rm_at8", mul_rm, 0);
      if (t == 9) chk("rm_at9", mul_rm, 1);
      if (t == 10) begin
        chk("rm_at10", mul_rm, 0);
        chk("rm_rne_o", bus.res_o, P_RNE);
      end
      if (t == 11) chk("rm_rtz_o", bus.res_o, P_RTZ);
      if (t == 12) chk("rm_none", bus.res_valid, 0);
    end

    // Drain with 3 ops in flight: pointer at 2, grants 2,3,0
    for (int i = 0; i < NREQ; i++) set_op(i, 128'(i + 1), 128'd0, 3'd0);
    go();
    bus.req_valid = 4'hF;
    #3;
    chk("drn_grant0", bus.req_ready, 4'b0100);
    go();
    #3;
    chk("drn_grant1", bus.req_ready, 4'b1000);
    go();
    #3;
    chk("drn_grant2", bus.req_ready, 4'b0001);
    for (int d = 3; d <= 14; d++) begin
      go();
      drain = (d == 3);
      bus.req_valid = (d < 13) ? 4'hF : 4'h0;
      #3;
      if (d < 13) chk("drn_no_grant", bus.req_ready, 0);
      chk("drn_done", drain_done, 128'(d == 13));
      if (d >= 10 && d <= 12) chk("drn_res_id", bus.res_id, 128'((d - 8) % 4));
      if (d == 13) chk("drn_inflight", inflight, 0);
    end

    // Drain while idle
    go();
    drain = 1'b1;
    #3;
    chk("idl_drain_done0", drain_done, 0);
    go();
    drain = 1'b0;
    #3;
    chk("idl_drain_done1", drain_done, 1);
    go();
    #3;
    chk("idl_drain_done2", drain_done, 0);

    // Reset with 5 ops in flight
    for (int f = 0; f < 5; f++) begin
      go();
      bus.req_valid = 4'hF;
      #3;
      if (f == 4) chk("mrst_inflight_pre", inflight, 4);
    end
    go();
    rst_n = 1'b0;
    bus.req_valid = 4'h0;
    #3;
    chk("mrst_res_valid", bus.res_valid, 0);
    chk("mrst_inflight", inflight, 0);
    chk("mrst_mul_ce", mul_ce, 1);
    chk("mrst_drain_done", drain_done, 0);
    chk("mrst_mul_rm", mul_rm, 0);
    chk("mrst_mul_a", mul_a, 0);
    chk("mrst_req_ready", bus.req_ready, 0);
    go(); go();
    rst_n = 1'b1;
    for (int r = 0; r < 12; r++) begin
      go();
      #3;
      chk("mrst_no_result", bus.res_valid, 0);
    end
    go();
    bus.req_valid = 4'hF;
    #3;
    chk("mrst_ptr0", bus.req_ready, 4'b0001);
    for (int k = 1; k <= 10; k++) begin
      go();
      bus.req_valid = 4'h0;
      #3;
      if (k == 10) begin
        chk("mrst_new_valid", bus.res_valid, 1);
        chk("mrst_new_id", bus.res_id, 0);
        chk("mrst_new_o", bus.res_o, 128'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
